// File: rtl/rr_arb4_v.sv
// rr_arb4_v: four-requester round-robin arbiter with a bounded hold time.
// It issues a registered one-hot grant that selects the input of a shared
// downstream resource. A holder is forced off after HOLD_MAX cycles, but only
// while another requester is waiting. Every grant end is followed by exactly
// one idle turnaround cycle, so grants are never back to back.
module rr_arb4_v #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_req,
    output logic [3:0] o_gnt,
    output logic [1:0] o_gnt_id,
    output logic       o_busy,
    output logic       o_any_req
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // The last cycle of a contended grant. The counter is compared against this value.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
    localparam logic [7:0] CNT_SAT   = 8'd255;

    state_t     state_q;
    logic [1:0] ptr_q;
    logic [7:0] cnt_q;
    logic [3:0] gnt_q;
    logic [1:0] gnt_id_q;
    logic       busy_q;

    logic [1:0] win_d;
    logic       contend_s;

    // Convert a 2-bit index into a one-hot 4-bit vector.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] v;
        v = 4'b0000;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Scan from ptr upward and wrap. Return the first requester found.
    // With no request set, it returns ptr. Callers only use the result when some request is set.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
                found = found;
            end
        end
        return pick;
    endfunction

    // This flag decides preemption. It ignores the holder's own request bit.
    // While idle, gnt_id_q may name a requester that is still asserting, so the flag is only used in GRANT.
    assign win_d     = rr_pick(i_req, ptr_q);
    assign contend_s = |(i_req & ~onehot4(gnt_id_q));
    assign o_any_req = |i_req;

    // Arbitration FSM. All outputs are registered here. Reset clears the grant immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 2'd0;
            cnt_q    <= 8'd0;
            gnt_q    <= 4'b0000;
            gnt_id_q <= 2'd0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|i_req) begin
                        state_q  <= ST_GRANT;
                        gnt_q    <= onehot4(win_d);
                        gnt_id_q <= win_d;
                        ptr_q    <= win_d + 2'd1;
                        cnt_q    <= 8'd0;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q  <= ST_IDLE;
                        gnt_q    <= 4'b0000;
                        busy_q   <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    if (!i_req[gnt_id_q]) begin
                        // The holder withdrew its request. This takes priority over preemption.
                        state_q <= ST_IDLE;
                        gnt_q   <= 4'b0000;
                        cnt_q   <= 8'd0;
                        busy_q  <= 1'b0;
                    end else if ((cnt_q == HOLD_LAST) && contend_s) begin
                        // The hold budget is used up and someone else is waiting.
                        state_q <= ST_IDLE;
                        gnt_q   <= 4'b0000;
                        cnt_q   <= 8'd0;
                        busy_q  <= 1'b0;
                    end else begin
                        // Keep the grant. The counter saturates so an uncontended holder never wraps.
                        state_q <= ST_GRANT;
                        busy_q  <= 1'b1;
                        if (cnt_q != CNT_SAT) begin
                            cnt_q <= cnt_q + 8'd1;
                        end else begin
                            cnt_q <= cnt_q;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= 4'b0000;
                    cnt_q   <= 8'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_gnt    = gnt_q;
    assign o_gnt_id = gnt_id_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_rr_arb4_v.sv
// Directed testbench for rr_arb4_v. It uses two instances: dut_a with HOLD_MAX=4 and dut_b with HOLD_MAX=1.
module tb_rr_arb4_v;

    logic       clk;
    logic       rst;
    logic [3:0] req_a, req_b;
    logic [3:0] gnt_a, gnt_b;
    logic [1:0] id_a, id_b;
    logic       busy_a, busy_b;
    logic       any_a, any_b;

    int checks = 0;
    int errors = 0;

    rr_arb4_v #(.HOLD_MAX(4)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_req(req_a),
        .o_gnt(gnt_a), .o_gnt_id(id_a), .o_busy(busy_a), .o_any_req(any_a)
    );

    rr_arb4_v #(.HOLD_MAX(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_req(req_b),
        .o_gnt(gnt_b), .o_gnt_id(id_b), .o_busy(busy_b), .o_any_req(any_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic onehot0(input logic [3:0] v);
        return (v & (v - 4'd1)) == 4'd0;
    endfunction

    // Advance one clock and sample at the falling edge. Then check the invariants that hold in every scenario.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_eq("any_a", {31'd0, any_a}, {31'd0, |req_a});
        check_eq("any_b", {31'd0, any_b}, {31'd0, |req_b});
        check_eq("onehot_a", {31'd0, onehot0(gnt_a)}, 32'd1);
        check_eq("onehot_b", {31'd0, onehot0(gnt_b)}, 32'd1);
    endtask

    // Expected o_gnt after each edge, with HOLD_MAX=4 and i_req=1111 starting from ptr=0.
    logic [3:0] rot_exp [21] = '{
        4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
        4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
        4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000,
        4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000,
        4'b0001
    };
    // Expected o_gnt with HOLD_MAX=1 and i_req=0011.
    logic [3:0] h1_exp [5] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001};
    // Fairness case: holder 1 drops, so requesters 3 and 0 contend with ptr=2.
    logic [3:0] fair_exp [7] = '{
        4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0001
    };

    initial begin
        rst   = 1'b1;
        req_a = 4'b0000;
        req_b = 4'b0000;
        #2;
        check_eq("rst_gnt", {28'd0, gnt_a}, 32'd0);
        check_eq("rst_id", {30'd0, id_a}, 32'd0);
        check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
        req_a = 4'b0101;
        #1;
        check_eq("rst_anyreq", {31'd0, any_a}, 32'd1);
        req_a = 4'b0000;
        @(negedge clk);
        rst = 1'b0;

        // Basic grant: one edge of latency.
        req_a = 4'b0001;
        step();
        check_eq("basic_gnt", {28'd0, gnt_a}, 32'h1);
        check_eq("basic_id", {30'd0, id_a}, 32'd0);
        check_eq("basic_busy", {31'd0, busy_a}, 32'd1);
        // Asynchronous reset in the middle of a cycle clears the grant before the next edge.
        #1 rst = 1'b1;
        #1;
        check_eq("async_gnt", {28'd0, gnt_a}, 32'd0);
        check_eq("async_busy", {31'd0, busy_a}, 32'd0);
        check_eq("async_anyreq", {31'd0, any_a}, 32'd1);
        @(negedge clk);
        req_a = 4'b0000;
        rst = 1'b0;

        // Full rotation under contention, with HOLD_MAX=4.
        req_a = 4'b1111;
        for (int i = 0; i < 21; i++) begin
            step();
            check_eq($sformatf("rot_%0d", i), {28'd0, gnt_a}, {28'd0, rot_exp[i]});
        end
        check_eq("rot_id", {30'd0, id_a}, 32'd0);
        req_a = 4'b0000;
        step();
        check_eq("rot_rel", {28'd0, gnt_a}, 32'd0);
        check_eq("rot_rel_id", {30'd0, id_a}, 32'd0);
        step();

        // A lone requester is never preempted. ptr is 1 here, so requester 2 wins.
        req_a = 4'b0100;
        step();
        for (int i = 0; i < 20; i++) begin
            check_eq($sformatf("lone_%0d", i), {28'd0, gnt_a}, 32'h4);
            if (i < 19) step();
        end
        req_a = 4'b0000;
        step();
        check_eq("lone_rel", {28'd0, gnt_a}, 32'd0);
        check_eq("lone_rel_id", {30'd0, id_a}, 32'd2);
        check_eq("lone_rel_busy", {31'd0, busy_a}, 32'd0);

        // A request that drops before it is sampled is never granted.
        req_a = 4'b0100;
        #2 req_a = 4'b0000;
        step();
        check_eq("glitch_gnt", {28'd0, gnt_a}, 32'd0);

        // Fairness: ptr=3 and requester 1 wins, so ptr becomes 2. Then requester 1 drops.
        req_a = 4'b0010;
        step();
        check_eq("fair_g1", {28'd0, gnt_a}, 32'h2);
        req_a = 4'b1001;
        for (int i = 0; i < 7; i++) begin
            step();
            check_eq($sformatf("fair_%0d", i), {28'd0, gnt_a}, {28'd0, fair_exp[i]});
        end
        check_eq("fair_id", {30'd0, id_a}, 32'd0);
        req_a = 4'b0000;
        step();

        // With HOLD_MAX=1, each grant lasts one cycle and is followed by a one-cycle gap.
        req_b = 4'b0011;
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq($sformatf("h1_%0d", i), {28'd0, gnt_b}, {28'd0, h1_exp[i]});
        end
        req_b = 4'b0000;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
